// File: rtl/obi_req_fifo_if.sv
// OBI request-channel bundle: req/gnt handshake plus address, write enable,
// byte enables and write data. The master drives the request, the slave grants.
interface obi_req_fifo_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   logic              req;
   logic              gnt;
   logic [ADDR_W-1:0] addr;
   logic              we;
   logic [BE_W-1:0]   be;
   logic [DATA_W-1:0] wdata;

   modport master (output req, addr, we, be, wdata, input gnt);
   modport slave  (input req, addr, we, be, wdata, output gnt);
endinterface

// File: rtl/obi_req_fifo.sv
// obi_req_fifo: DEPTH-entry OBI request buffer with occupancy, flush and an optional
// zero-latency bypass, enabled by defining OBI_REQ_FIFO_BYPASS_EN.

// Downstream invariants: bounded occupancy, a pending head never changes, idle bus is all-zero.
module obi_req_fifo_chk #(
   parameter int DEPTH = 2,
   parameter int LVL_W = 2,
   parameter int ENT_W = 69
) (
   input logic             clk_i,
   input logic             rst_i,
   input logic             flush_i,
   input logic             req,
   input logic             gnt,
   input logic [ENT_W-1:0] head,
   input logic [LVL_W-1:0] level
);
   a_level_bound: assert property (@(posedge clk_i) disable iff (rst_i)
      level <= LVL_W'(DEPTH));
   a_head_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (req && !gnt && !flush_i) |=> (req && $stable(head)));
   a_idle_zero: assert property (@(posedge clk_i) disable iff (rst_i)
      !req |-> (head == {ENT_W{1'b0}}));
endmodule

module obi_req_fifo #(
   parameter int  DEPTH  = 2,
   parameter int  ADDR_W = 32,
   parameter int  DATA_W = 32,
   localparam int BE_W   = DATA_W / 8,
   localparam int LVL_W  = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   obi_req_fifo_if.slave    up,
   obi_req_fifo_if.master   dn,
   output logic [LVL_W-1:0] level_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [BE_W-1:0]   be;
      logic [DATA_W-1:0] wdata;
   } entry_t;

   localparam int     ENT_W      = $bits(entry_t);
   localparam entry_t ENTRY_ZERO = {ENT_W{1'b0}};

   entry_t           mem_r [DEPTH];
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [LVL_W-1:0] level_r;

   logic   empty_s;
   logic   full_s;
   logic   gnt_s;
   logic   push_s;
   logic   pop_s;
   logic   req_out_s;
   entry_t in_s;
   entry_t head_s;
   entry_t out_s;
`ifdef OBI_REQ_FIFO_BYPASS_EN
   logic   byp_s;
`endif

   // Circular increment; DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_LAST) begin
         ptr_inc = {PTR_W{1'b0}};
      end else begin
         ptr_inc = p + PTR_W'(1);
      end
   endfunction

   // Occupancy flags, head read-out and packing of the incoming request.
   always_comb begin
      empty_s = (level_r == {LVL_W{1'b0}});
      full_s  = (level_r == LVL_FULL);
      head_s  = mem_r[rd_ptr_r];
      in_s    = {up.addr, up.we, up.be, up.wdata};
   end

   // Accept rule and push/pop decisions; reset blocks any grant.
   always_comb begin
      gnt_s  = 1'b0;
      push_s = 1'b0;
      pop_s  = 1'b0;
`ifdef OBI_REQ_FIFO_BYPASS_EN
      byp_s  = 1'b0;
`endif
      if (rst_i) begin
         gnt_s = 1'b0;
      end else begin
         // A full buffer still accepts when its head leaves in the same cycle.
         gnt_s = up.req & ~flush_i & (~full_s | dn.gnt);
         pop_s = ~empty_s & dn.gnt;
`ifdef OBI_REQ_FIFO_BYPASS_EN
         byp_s  = empty_s & ~flush_i;
         // A request granted straight through the bypass is never stored.
         push_s = gnt_s & ~(byp_s & dn.gnt);
`else
         push_s = gnt_s;
`endif
      end
   end

   // Downstream view: head entry when buffered, otherwise zeros (or the bypassed input).
   always_comb begin
      req_out_s = 1'b0;
      out_s     = ENTRY_ZERO;
      if (!empty_s) begin
         req_out_s = 1'b1;
         out_s     = head_s;
`ifdef OBI_REQ_FIFO_BYPASS_EN
      end else if (byp_s && up.req) begin
         req_out_s = 1'b1;
         out_s     = in_s;
`endif
      end else begin
         req_out_s = 1'b0;
         out_s     = ENTRY_ZERO;
      end
   end

   assign up.gnt   = gnt_s;
   assign dn.req   = req_out_s;
   assign dn.addr  = out_s.addr;
   assign dn.we    = out_s.we;
   assign dn.be    = out_s.be;
   assign dn.wdata = out_s.wdata;
   assign level_o  = level_r;

   // Storage, pointers and level; reset dominates flush, flush dominates push/pop.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         level_r  <= {LVL_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= ENTRY_ZERO;
         end
      end else if (flush_i) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         level_r  <= {LVL_W{1'b0}};
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= in_s;
            wr_ptr_r        <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + LVL_W'(1);
            2'b01:   level_r <= level_r - LVL_W'(1);
            default: level_r <= level_r;
         endcase
      end
   end

   obi_req_fifo_chk #(
      .DEPTH (DEPTH),
      .LVL_W (LVL_W),
      .ENT_W (ENT_W)
   ) u_chk (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .req     (req_out_s),
      .gnt     (dn.gnt),
      .head    (out_s),
      .level   (level_r)
   );
endmodule
